// File: rtl/rf_wb_arbiter_pkg.sv
// Shared write-back control types and default register-file geometry.
package rf_ctrl_pkg;

  localparam int unsigned RF_DATA_W  = 32;
  localparam int unsigned RF_ADDR_W  = 5;
  localparam int unsigned RF_NUM_REG = 32;

  // Which requester wins when both ALU and load-return are valid.
  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_ALU = 1'b1
  } pri_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus: ALU/load requests, load issue, hazard lookup, RF write port.
interface rf_wb_arbiter_if
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
);

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_adr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              issue_load;
  logic [ADDR_W-1:0] issue_adr;

  logic [ADDR_W-1:0] chk_adr1;
  logic [ADDR_W-1:0] chk_adr2;
  logic              stall;

  logic              rf_en;
  logic [ADDR_W-1:0] rf_w_adr;
  logic [DATA_W-1:0] rf_w_data;

  // Pipeline side: drives requests and lookups, observes grants and RF port.
  modport master (
    output alu_valid, alu_adr, alu_data,
    output mem_valid, mem_adr, mem_data,
    output issue_load, issue_adr, chk_adr1, chk_adr2,
    input  alu_ready, mem_ready, stall, rf_en, rf_w_adr, rf_w_data
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_adr, alu_data,
    input  mem_valid, mem_adr, mem_data,
    input  issue_load, issue_adr, chk_adr1, chk_adr2,
    output alu_ready, mem_ready, stall, rf_en, rf_w_adr, rf_w_data
  );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue,
// cleared on load write-back, looked up for the two decode sources.
module wb_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter int unsigned NUM_REG = RF_NUM_REG
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_adr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_adr,
  input  logic [ADDR_W-1:0] chk_adr1,
  input  logic [ADDR_W-1:0] chk_adr2,
  output logic              stall
);

  localparam logic [NUM_REG-1:0] ONE = {{(NUM_REG-1){1'b0}}, 1'b1};

  logic [NUM_REG-1:0] pending;
  logic [NUM_REG-1:0] set_vec;
  logic [NUM_REG-1:0] clr_vec;

  // Decode set/clear into one-hot masks; x0 can never become pending.
  always_comb begin
    set_vec    = set_en ? (ONE << set_adr) : '0;
    set_vec[0] = 1'b0;
    clr_vec    = clr_en ? (ONE << clr_adr) : '0;
  end

  // Set is applied after clear so a newly issued load supersedes the old one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pending <= '0;
    else     pending <= (pending & ~clr_vec) | set_vec;
  end

  // Read-after-load hazard lookup for both decode sources.
  always_comb begin
    stall = pending[chk_adr1] | pending[chk_adr2];
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back controller: round-robin arbitration between the
// ALU and load-return paths, registered RF write port, pending-load scoreboard.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter int unsigned NUM_REG = RF_NUM_REG
) (
  input  logic          CLK,
  input  logic          RST,
  rf_wb_arbiter_if.slave bus
);

  pri_e              state;
  logic              grant_alu;
  logic              grant_mem;
  logic              en_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] data_q;

  // Grant: a lone requester always wins, a tie goes to the favoured side;
  // nothing is granted while reset is asserted.
  always_comb begin
    grant_mem = !RST && bus.mem_valid && (!bus.alu_valid || state == PRI_MEM);
    grant_alu = !RST && bus.alu_valid && (!bus.mem_valid || state == PRI_ALU);
  end

  // Priority FSM and registered RF write port; x0 writes are accepted but dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= PRI_MEM;
      en_q   <= 1'b0;
      adr_q  <= '0;
      data_q <= '0;
    end else if (grant_mem) begin
      state  <= PRI_ALU;
      en_q   <= |bus.mem_adr;
      adr_q  <= bus.mem_adr;
      data_q <= bus.mem_data;
    end else if (grant_alu) begin
      state  <= PRI_MEM;
      en_q   <= |bus.alu_adr;
      adr_q  <= bus.alu_adr;
      data_q <= bus.alu_data;
    end else begin
      en_q   <= 1'b0;
    end
  end

  assign bus.mem_ready = grant_mem;
  assign bus.alu_ready = grant_alu;
  assign bus.rf_en     = en_q;
  assign bus.rf_w_adr  = adr_q;
  assign bus.rf_w_data = data_q;

  wb_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_REG (NUM_REG)
  ) u_scoreboard (
    .CLK      (CLK),
    .RST      (RST),
    .set_en   (bus.issue_load),
    .set_adr  (bus.issue_adr),
    .clr_en   (grant_mem),
    .clr_adr  (bus.mem_adr),
    .chk_adr1 (bus.chk_adr1),
    .chk_adr2 (bus.chk_adr2),
    .stall    (bus.stall)
  );

endmodule
